// File: rtl/freq_meas_pkg.sv
// Shared types and constants for the measurement sequencer.
package freq_meas_pkg;

    localparam int unsigned DEF_CNT_W = 32;
    // Legacy fixed gate length in clk_100M cycles.
    localparam int unsigned GATE_1S   = 100_000_000;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StOpen,
        StClose,
        StLatch,
        StHold
    } meas_state_t;

endpackage

// File: rtl/meas_dncnt.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
module meas_dncnt #(
    parameter int unsigned W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;
    logic         w_tc;

    assign w_tc = (r_cnt == '0);
    assign o_tc = w_tc;

    // Saturates at zero so a late enable never wraps into a huge count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && !w_tc) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

endmodule

// File: rtl/freq_meas_seq.sv
// Edge-aligned gate sequencer for the reciprocal frequency/duty counter datapath,
// with a no-signal timeout and a valid/ready result handshake.
module freq_meas_seq
    import freq_meas_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk_100M,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cfg_continuous,
    input  logic [CNT_W-1:0] cfg_gate_cycles,
    input  logic [CNT_W-1:0] cfg_timeout,
    input  logic             squ_pose,
    output logic             meas_clr,
    output logic             meas_gate,
    output logic             meas_latch,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_timeout,
    output logic             busy
);

    meas_state_t      r_state;
    meas_state_t      w_state_d;

    logic [CNT_W-1:0] r_cfg_gate;
    logic [CNT_W-1:0] r_cfg_timeout;

    logic             r_clr;
    logic             r_gate;
    logic             r_latch;
    logic             r_valid;
    logic             r_timeout;
    logic             r_busy;

    logic             w_clr_d;
    logic             w_timeout_d;
    logic             w_to_fire;
    logic             w_to_en;
    logic             w_capture;

    logic             w_gate_load;
    logic [CNT_W-1:0] w_gate_load_val;
    logic             w_gate_cnt_en;
    logic             w_gate_tc;

    logic             w_to_load;
    logic [CNT_W-1:0] w_to_load_val;
    logic             w_to_cnt_en;
    logic             w_to_tc;

    assign w_to_en = (r_cfg_timeout != '0);

    always_comb begin
        w_state_d = r_state;
        w_clr_d   = 1'b0;
        w_to_fire = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start || cfg_continuous) begin
                    w_state_d = StArm;
                    // In continuous mode the clear was already issued on acceptance.
                    w_clr_d   = !r_clr;
                end
            end
            StArm: begin
                if (squ_pose) begin
                    w_state_d = StOpen;
                end else if (w_to_en && w_to_tc) begin
                    w_state_d = StHold;
                    w_to_fire = 1'b1;
                end
            end
            StOpen: begin
                if (w_gate_tc) begin
                    w_state_d = StClose;
                end
            end
            StClose: begin
                if (squ_pose) begin
                    w_state_d = StLatch;
                end else if (w_to_en && w_to_tc) begin
                    w_state_d = StHold;
                    w_to_fire = 1'b1;
                end
            end
            StLatch: begin
                w_state_d = StHold;
            end
            StHold: begin
                if (res_ready) begin
                    w_state_d = StIdle;
                    w_clr_d   = cfg_continuous;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
        if (abort) begin
            w_state_d = StIdle;
            w_clr_d   = 1'b0;
            w_to_fire = 1'b0;
        end
    end

    // Timeout status is decided on HOLD entry and frozen while HOLD lasts.
    always_comb begin
        w_timeout_d = 1'b0;
        if (w_state_d == StHold) begin
            w_timeout_d = (r_state == StHold) ? r_timeout : w_to_fire;
        end
    end

    assign w_capture = (r_state == StIdle) && (w_state_d == StArm);

    assign w_gate_load     = (w_state_d == StOpen) && (r_state != StOpen);
    assign w_gate_load_val = (r_cfg_gate == '0) ? '0 : r_cfg_gate - CNT_W'(1);
    assign w_gate_cnt_en   = (r_state == StOpen);

    assign w_to_load     = ((w_state_d == StArm) && (r_state != StArm)) ||
                           ((w_state_d == StClose) && (r_state != StClose));
    assign w_to_load_val = (r_state == StIdle) ? cfg_timeout : r_cfg_timeout;
    assign w_to_cnt_en   = (r_state == StArm) || (r_state == StClose);

    meas_dncnt #(
        .W (CNT_W)
    ) u_gate_cnt (
        .i_clk      (clk_100M),
        .i_rst_n    (rst_n),
        .i_load     (w_gate_load),
        .i_load_val (w_gate_load_val),
        .i_en       (w_gate_cnt_en),
        .o_tc       (w_gate_tc)
    );

    meas_dncnt #(
        .W (CNT_W)
    ) u_to_cnt (
        .i_clk      (clk_100M),
        .i_rst_n    (rst_n),
        .i_load     (w_to_load),
        .i_load_val (w_to_load_val),
        .i_en       (w_to_cnt_en),
        .o_tc       (w_to_tc)
    );

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_gate    <= '0;
            r_cfg_timeout <= '0;
        end else if (w_capture) begin
            r_cfg_gate    <= cfg_gate_cycles;
            r_cfg_timeout <= cfg_timeout;
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_clr     <= 1'b0;
            r_gate    <= 1'b0;
            r_latch   <= 1'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_clr     <= w_clr_d;
            r_gate    <= (w_state_d == StOpen) || (w_state_d == StClose);
            r_latch   <= (w_state_d == StLatch);
            r_valid   <= (w_state_d == StHold);
            r_timeout <= w_timeout_d;
            r_busy    <= (w_state_d != StIdle);
        end
    end

    assign meas_clr    = r_clr;
    assign meas_gate   = r_gate;
    assign meas_latch  = r_latch;
    assign res_valid   = r_valid;
    assign res_timeout = r_timeout;
    assign busy        = r_busy;

endmodule

// File: doc/freq_meas_seq.md
# freq_meas_seq

Measurement sequencer for the reciprocal frequency/duty counter datapath. Replaces the free-running fixed 1 s gate with a programmable, edge-aligned gate: arms on request, opens the gate on a rising edge of the measured signal, holds it for at least a configured number of `clk_100M` cycles, closes it on the next rising edge, then commands the datapath to latch and presents a valid/ready result strobe to the readout logic. Adds a no-signal timeout so a dead input never stalls the system.

## Interface

**Parameters**
- `CNT_W`, 32: width of gate-length and timeout counters and config inputs.

**Ports**
- `clk_100M`, in, 1: system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: one-cycle request to run one measurement; honoured only in IDLE.
- `abort`, in, 1: synchronous abort; returns to IDLE from any state, no result.
- `cfg_continuous`, in, 1: re-arm automatically after each result is consumed.
- `cfg_gate_cycles`, in, CNT_W: minimum gate length in clocks; 0 is treated as 1.
- `cfg_timeout`, in, CNT_W: max clocks to wait for an edge in ARM or CLOSE; 0 disables the timeout.
- `squ_pose`, in, 1: one-cycle rising-edge pulse of the already-synchronised measured signal.
- `meas_clr`, out, 1: one-cycle clear of datapath counters.
- `meas_gate`, out, 1: gate enable to the datapath counters.
- `meas_latch`, out, 1: one-cycle command for the datapath to copy its counters to the result registers.
- `res_valid`, out, 1: result (or timeout status) available.
- `res_ready`, in, 1: consumer accepts the result.
- `res_timeout`, out, 1: qualifies `res_valid`; 1 = measurement aborted by timeout, counts invalid.
- `busy`, out, 1: state ≠ IDLE.

## Operation
- States: IDLE, ARM, OPEN, CLOSE, LATCH, HOLD.
- **IDLE**: on `start`, or on `cfg_continuous`=1, → ARM, with `meas_clr`=1 in the transition cycle. `cfg_gate_cycles` and `cfg_timeout` are captured in the same cycle; they are ignored for the rest of the run.
- **ARM**: waits for `squ_pose`; on the edge → OPEN. Timeout expiry → HOLD with `res_timeout`=1.
- **OPEN**: `meas_gate`=1. Counts captured gate cycles; after the last one → CLOSE. `squ_pose` is ignored.
- **CLOSE**: `meas_gate`=1. On `squ_pose` → LATCH. Timeout expiry → HOLD with `res_timeout`=1, and `meas_gate` drops.
- **LATCH**: `meas_gate`=0, `meas_latch`=1 for exactly one cycle → HOLD.
- **HOLD**: `res_valid`=1 and `res_timeout` held stable until `res_valid & res_ready`. Then → IDLE, or → ARM with `meas_clr` if `cfg_continuous`=1.
- Timeout counter restarts on every entry to ARM and CLOSE. Expiry fires when it reaches the captured `cfg_timeout` clocks without an edge.
- An edge in the same cycle as expiry wins; no timeout is flagged.
- `abort` has priority over all transitions: → IDLE, all strobes 0, `res_valid` cleared. `start` during a run is ignored.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `meas_clr`, `meas_gate`, `meas_latch`, `res_valid`, `res_timeout`, `busy` all 0.
- `squ_pose` accepted in ARM at cycle t → `meas_gate`=1 from t+1.
- OPEN lasts exactly N = max(`cfg_gate_cycles`,1) cycles (t+1..t+N). An edge in cycle t+N does not close the gate.
- `squ_pose` in CLOSE at cycle e → `meas_gate`=0 and `meas_latch`=1 at e+1, `res_valid`=1 at e+2.
- The gate therefore spans an integer number of input periods, and is at least N clocks long.
- Handshake: `res_valid` must not drop without `res_ready` (except for `abort` or reset). Acceptance at cycle a → `res_valid`=0 at a+1.
- Continuous mode: `meas_clr` at a+1, ARM active from a+2.
- Reset mid-run: immediate return to reset values; no `meas_latch` is issued.

## Structure
- Package `freq_meas_pkg` holds:
  - the state enum `meas_state_t`
  - the `CNT_W` default
  - the constant `GATE_1S` = 100_000_000
- One sub-module, `meas_dncnt`: loadable down-counter with a terminal-count flag.
  - Instantiated twice: gate length and timeout.
- The sequencer FSM stays in the top module.

## Test plan
- `cfg_gate_cycles`=100, square with period 10 clocks, `start` → `meas_gate` high exactly 110 cycles, one `meas_latch`, `res_valid`=1 with `res_timeout`=0, held until `res_ready`.
- `cfg_gate_cycles`=0 with the same square → gate treated as 1 cycle; closes on the next edge, so `meas_gate` is high for 10 cycles.
- No input edges, `cfg_timeout`=50, `start` → `res_valid`=1 with `res_timeout`=1 at 51 cycles after ARM entry; `meas_gate` never rises.
- `cfg_continuous`=1, `res_ready` tied 1 → back-to-back measurements, `meas_clr` pulse between each; `res_ready` held 0 for 20 cycles → `res_valid` stays high and no new `meas_clr` is issued.
- `abort` asserted in CLOSE, and separately `rst_n` asserted low in OPEN → next cycle IDLE (abort) / immediately IDLE (reset), all outputs 0, no `meas_latch`, no `res_valid`.
- Edge coincident with timeout expiry in CLOSE → normal LATCH, `res_timeout`=0.
